redmule_x_tile_fifo: RTL and testbench
======================================

Name: redmule_x_tile_fifo

Overview:
- Next-generation X-operand staging buffer for the RedMulE datapath.
- Generalises the fixed two-slot ping-pong scheme into a parametrised circular FIFO of NumSlots complete W×H tiles.
- Adds valid/ready handshakes on both sides, per-tile zero padding of partial tiles, and a tile-reuse (replay) mode so one X tile can feed several Y/W column passes without reloading.
- Sits between the X streamer (row beats) and the engine array input (full W×H tile).

Parameters:
- FpFormat, fpnew_pkg::FP16, element format; BITW = fp_width(FpFormat).
- Height, ARRAY_HEIGHT, elements per row (H).
- Width, ARRAY_WIDTH, rows per tile (W).
- NumSlots, 2, tile slots; must be >= 1, need not be a power of two.
- MaxReuse, 16, maximum replay count per tile; RW = $clog2(MaxReuse)+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- cfg_load_i  in  1  latch cfg_* fields
- cfg_width_i  in  $clog2(W)+1  valid rows per tile, 1..W
- cfg_height_i  in  $clog2(H)+1  valid elements per row, 1..H
- cfg_reuse_i  in  RW  times each tile is presented, 1..MaxReuse
- in_valid_i  in  1  row beat valid
- in_ready_o  out  1  row beat accepted
- in_data_i  in  H*BITW  one tile row, element 0 in LSBs
- out_valid_o  out  1  head tile available
- out_ready_i  in  1  consumer takes current presentation
- out_data_o  out  [W-1:0][H-1:0][BITW-1:0]  head tile
- out_last_o  out  1  current presentation is the final reuse of the head tile
- flags_o  out  x_tile_fifo_flgs_t  {full, empty, level[$clog2(NumSlots):0]}

Behaviour:
- Reset/clear state:
  - All slots invalid; write/read pointers, row counter and reuse counter = 0.
  - Config = {W, H, 1}.
  - in_ready_o = 1, out_valid_o = 0, out_last_o = 0, out_data_o = 0, flags {full=0, empty=1, level=0}.
  - A partial tile in progress is discarded.
- Config:
  - cfg_load_i takes effect only when empty=1 and the row counter is 0; otherwise it is ignored.
  - Values are clamped: width 0 → 1, width > W → W; height likewise against H; reuse 0 → 1, reuse > MaxReuse → MaxReuse.
- Write side:
  - in_ready_o = ~full.
  - On each accepted beat, row row_cnt of slot wr_ptr is written; elements with index >= cfg_height are written as 0.
  - On acceptance of the beat with row_cnt == cfg_width-1:
    - Rows cfg_width..W-1 of that slot are forced to 0.
    - The slot is committed (valid next cycle).
    - row_cnt returns to 0 and wr_ptr advances, wrapping at NumSlots-1 → 0.
- Read side:
  - out_valid_o = slot[rd_ptr].valid.
  - out_data_o is driven directly from slot storage and is 0 when not valid.
  - A committed tile appears on out_valid_o one cycle after its last beat is accepted.
  - On each out_valid_o & out_ready_i, reuse_cnt increments.
  - out_last_o = out_valid_o & (reuse_cnt == cfg_reuse-1).
  - A handshake with out_last_o set frees the slot, clears reuse_cnt and advances rd_ptr with wrap.
- Level and flags:
  - level += commit, −= free.
  - A simultaneous commit and free leaves level unchanged.
  - full = (level == NumSlots); empty = (level == 0).
- Backpressure: data and flags must be held stable while out_valid_o=1 and out_ready_i=0.
- Full boundary: with level == NumSlots, the free handshake and a new in_valid_i in the same cycle does NOT accept the beat (in_ready_o is registered-full based). The beat is accepted next cycle.
- Precedence: rst_i and clear_i override all other activity in the same cycle.

Decomposition:
- redmule_pkg additions:
  - x_tile_fifo_cfg_t {width, height, reuse}
  - x_tile_fifo_flgs_t {full, empty, level}
  - constant X_FIFO_MAX_REUSE = 16
- Sub-module redmule_x_tile_slot holds one W×H tile register array. It provides:
  - row write enable and row address
  - element zero mask
  - a "zero rows >= width" commit strobe
  - a full-tile read port
- The top instantiates NumSlots copies and adds the pointer/counter/handshake logic.

Test Plan:
- Bench configuration for all scenarios: W=4, H=4, NumSlots=2, FP16.
- Reset then idle → in_ready_o=1, out_valid_o=0, flags {0,1,0}, out_data_o=0.
- cfg {4,4,1}; stream rows 0x1000+r*4+e → out_valid_o rises exactly one cycle after 4th beat; out_last_o=1; out_data_o[r][e] matches.
- cfg {3,2,1}; send 3 beats all 0xFFFF → rows 0–2 hold elements 0–1 = 0xFFFF, elements 2–3 = 0; row 3 all 0.
- cfg reuse=3, out_ready_i toggled 1,0,1,1 → the tile is presented 3 times; out_last_o only on the 3rd; slot frees after the 3rd handshake; level goes 1→0.
- Fill 2 tiles with out_ready_i=0 → full=1, in_ready_o=0. Then with out_ready_i=1 and in_valid_i held, level holds at 2 on the free cycle, and a third tile completes later without data corruption; rd/wr pointers wrap.
- Assert clear_i mid-tile (after 2 beats, 1 tile committed) → next cycle flags {0,1,0}, out_valid_o=0; new 4-beat tile output is correct with no residue of old rows.

Source files
------------

// File: rtl/redmule_x_tile_fifo_pkg.sv
// Shared types and constants for the RedMulE X-operand tile FIFO.
// Struct field widths follow the default array geometry and slot count.
package redmule_x_tile_fifo_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 16;
        endcase
    endfunction

    localparam int unsigned ARRAY_WIDTH      = 4;
    localparam int unsigned ARRAY_HEIGHT     = 4;
    localparam int unsigned X_FIFO_MAX_REUSE = 16;
    localparam int unsigned X_FIFO_NUM_SLOTS = 2;

    localparam int unsigned X_FIFO_WIDTH_W  = $clog2(ARRAY_WIDTH) + 1;
    localparam int unsigned X_FIFO_HEIGHT_W = $clog2(ARRAY_HEIGHT) + 1;
    localparam int unsigned X_FIFO_REUSE_W  = $clog2(X_FIFO_MAX_REUSE) + 1;
    localparam int unsigned X_FIFO_LEVEL_W  = $clog2(X_FIFO_NUM_SLOTS) + 1;

    typedef struct packed {
        logic [X_FIFO_WIDTH_W-1:0]  width;
        logic [X_FIFO_HEIGHT_W-1:0] height;
        logic [X_FIFO_REUSE_W-1:0]  reuse;
    } x_tile_fifo_cfg_t;

    typedef struct packed {
        logic                      full;
        logic                      empty;
        logic [X_FIFO_LEVEL_W-1:0] level;
    } x_tile_fifo_flgs_t;

    // Zero is promoted to one and anything above the limit saturates.
    function automatic int unsigned clamp_field(input int unsigned val,
                                                input int unsigned max_val);
        if (val == 0)
            return 1;
        else if (val > max_val)
            return max_val;
        else
            return val;
    endfunction

endpackage

// File: rtl/redmule_x_tile_fifo_if.sv
// Configuration, row-beat input and tile output bundle of the X tile FIFO.
// The FIFO sits on the slave modport; streamer/engine side uses master.
interface redmule_x_tile_fifo_if
    import redmule_x_tile_fifo_pkg::*;
#(
    parameter int unsigned Width  = ARRAY_WIDTH,
    parameter int unsigned Height = ARRAY_HEIGHT,
    parameter int unsigned BITW   = 16
) ();

    logic                                    cfg_load_i;
    logic [X_FIFO_WIDTH_W-1:0]               cfg_width_i;
    logic [X_FIFO_HEIGHT_W-1:0]              cfg_height_i;
    logic [X_FIFO_REUSE_W-1:0]               cfg_reuse_i;

    logic                                    in_valid_i;
    logic                                    in_ready_o;
    logic [Height*BITW-1:0]                  in_data_i;

    logic                                    out_valid_o;
    logic                                    out_ready_i;
    logic [Width-1:0][Height-1:0][BITW-1:0]  out_data_o;
    logic                                    out_last_o;
    x_tile_fifo_flgs_t                       flags_o;

    modport slave (
        input  cfg_load_i, cfg_width_i, cfg_height_i, cfg_reuse_i,
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, flags_o
    );

    modport master (
        output cfg_load_i, cfg_width_i, cfg_height_i, cfg_reuse_i,
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, flags_o
    );

endinterface

// File: rtl/redmule_x_tile_fifo_slot.sv
// One W x H tile register array with masked row writes and a commit strobe
// that blanks every row at or above the configured tile width.
module redmule_x_tile_fifo_slot #(
    parameter int unsigned Width  = 4,
    parameter int unsigned Height = 4,
    parameter int unsigned BITW   = 16,
    parameter int unsigned RowAW  = (Width > 1) ? $clog2(Width) : 1,
    parameter int unsigned WidthW = $clog2(Width) + 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   row_we,
    input  logic [RowAW-1:0]                       row_addr,
    input  logic [Height*BITW-1:0]                 row_data,
    input  logic [Height-1:0]                      zero_mask,
    input  logic                                   commit,
    input  logic [WidthW-1:0]                      width,
    output logic [Width-1:0][Height-1:0][BITW-1:0] tile
);

    logic [Width-1:0][Height-1:0][BITW-1:0] tile_q;

    // The committing beat always targets row width-1, so it never collides
    // with the rows that the commit strobe blanks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tile_q <= '0;
        end else begin
            if (row_we) begin
                for (int e = 0; e < Height; e++) begin
                    tile_q[row_addr][e] <= zero_mask[e] ? '0 : row_data[e*BITW +: BITW];
                end
            end
            if (commit) begin
                for (int r = 0; r < Width; r++) begin
                    if (r >= int'(width)) begin
                        tile_q[r] <= '0;
                    end
                end
            end
        end
    end

    assign tile = tile_q;

endmodule

// File: rtl/redmule_x_tile_fifo.sv
// Circular FIFO of complete X tiles between the X streamer and the engine array,
// with partial-tile zero padding and per-tile replay.
module redmule_x_tile_fifo
    import redmule_x_tile_fifo_pkg::*;
#(
    parameter fp_format_e  FpFormat = FP16,
    parameter int unsigned Height   = ARRAY_HEIGHT,
    parameter int unsigned Width    = ARRAY_WIDTH,
    parameter int unsigned NumSlots = X_FIFO_NUM_SLOTS,
    parameter int unsigned MaxReuse = X_FIFO_MAX_REUSE
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    redmule_x_tile_fifo_if.slave        bus
);

    localparam int unsigned BITW  = fp_width(FpFormat);
    localparam int unsigned PtrW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam int unsigned RowAW = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned WW    = X_FIFO_WIDTH_W;
    localparam int unsigned HW    = X_FIFO_HEIGHT_W;
    localparam int unsigned RW    = X_FIFO_REUSE_W;
    localparam int unsigned LW    = X_FIFO_LEVEL_W;

    typedef logic [Width-1:0][Height-1:0][BITW-1:0] tile_t;

    x_tile_fifo_cfg_t    cfg_q;
    x_tile_fifo_cfg_t    cfg_clamped;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [WW-1:0]       row_cnt_q;
    logic [RW-1:0]       reuse_cnt_q;
    logic [LW-1:0]       level_q;
    logic [NumSlots-1:0] slot_valid_q;
    tile_t               slot_tile [NumSlots];

    logic                flush;
    logic                full;
    logic                empty;
    logic                in_fire;
    logic                last_row;
    logic                commit;
    logic                out_valid;
    logic                out_last;
    logic                out_fire;
    logic                free;
    logic                cfg_take;
    logic [Height-1:0]   zero_mask;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(NumSlots - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign flush    = rst_i | clear_i;
    assign full     = (level_q == LW'(NumSlots));
    assign empty    = (level_q == '0);
    assign in_fire  = bus.in_valid_i & ~full;
    assign last_row = (row_cnt_q == cfg_q.width - WW'(1));
    assign commit   = in_fire & last_row;

    assign out_valid = slot_valid_q[rd_ptr_q];
    assign out_last  = out_valid & (reuse_cnt_q == cfg_q.reuse - RW'(1));
    assign out_fire  = out_valid & bus.out_ready_i;
    assign free      = out_fire & out_last;

    // Reconfiguring is only safe between tiles with nothing buffered.
    assign cfg_take = bus.cfg_load_i & empty & (row_cnt_q == '0);

    always_comb begin
        cfg_clamped        = cfg_q;
        cfg_clamped.width  = WW'(clamp_field(32'(bus.cfg_width_i), Width));
        cfg_clamped.height = HW'(clamp_field(32'(bus.cfg_height_i), Height));
        cfg_clamped.reuse  = RW'(clamp_field(32'(bus.cfg_reuse_i), MaxReuse));
    end

    always_comb begin
        zero_mask = '0;
        for (int e = 0; e < Height; e++) begin
            zero_mask[e] = (e >= int'(cfg_q.height));
        end
    end

    // Pointer, counter and occupancy bookkeeping; clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            cfg_q        <= '{width: WW'(Width), height: HW'(Height), reuse: RW'(1)};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            row_cnt_q    <= '0;
            reuse_cnt_q  <= '0;
            level_q      <= '0;
            slot_valid_q <= '0;
        end else begin
            if (cfg_take) begin
                cfg_q <= cfg_clamped;
            end
            if (in_fire) begin
                row_cnt_q <= last_row ? '0 : row_cnt_q + WW'(1);
            end
            if (commit) begin
                wr_ptr_q               <= ptr_inc(wr_ptr_q);
                slot_valid_q[wr_ptr_q] <= 1'b1;
            end
            if (out_fire) begin
                reuse_cnt_q <= free ? '0 : reuse_cnt_q + RW'(1);
            end
            if (free) begin
                rd_ptr_q               <= ptr_inc(rd_ptr_q);
                slot_valid_q[rd_ptr_q] <= 1'b0;
            end
            if (commit && !free) begin
                level_q <= level_q + LW'(1);
            end else if (free && !commit) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        redmule_x_tile_fifo_slot #(
            .Width  (Width),
            .Height (Height),
            .BITW   (BITW),
            .RowAW  (RowAW),
            .WidthW (WW)
        ) i_slot (
            .clk_i     (clk_i),
            .rst_i     (flush),
            .row_we    (in_fire && (wr_ptr_q == PtrW'(s))),
            .row_addr  (row_cnt_q[RowAW-1:0]),
            .row_data  (bus.in_data_i),
            .zero_mask (zero_mask),
            .commit    (commit && (wr_ptr_q == PtrW'(s))),
            .width     (cfg_q.width),
            .tile      (slot_tile[s])
        );
    end

    always_comb begin
        bus.out_data_o = '0;
        if (out_valid) begin
            bus.out_data_o = slot_tile[rd_ptr_q];
        end
    end

    assign bus.in_ready_o  = ~full;
    assign bus.out_valid_o = out_valid;
    assign bus.out_last_o  = out_last;
    assign bus.flags_o     = '{full: full, empty: empty, level: level_q};

endmodule

// File: tb/tb_redmule_x_tile_fifo.sv
// Directed self-checking bench for redmule_x_tile_fifo with a 4x4 FP16 geometry
// and two slots; each scenario task carries its own hand-derived expectations.
module tb_redmule_x_tile_fifo;
    import redmule_x_tile_fifo_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned NS = 2;
    localparam int unsigned BW = 16;

    typedef logic [W-1:0][H-1:0][BW-1:0] tile_t;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   total = 0;
    int   bad   = 0;

    redmule_x_tile_fifo_if #(.Width(W), .Height(H), .BITW(BW)) bus ();

    redmule_x_tile_fifo #(
        .FpFormat (FP16),
        .Height   (H),
        .Width    (W),
        .NumSlots (NS),
        .MaxReuse (16)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [H*BW-1:0] mk_row(input logic [15:0] base, input int r);
        logic [H*BW-1:0] row;
        for (int e = 0; e < H; e++) row[e*BW +: BW] = base + 16'(r*4 + e);
        return row;
    endfunction

    function automatic tile_t mk_tile(input logic [15:0] base, input int w, input int h);
        tile_t t;
        for (int r = 0; r < W; r++)
            for (int e = 0; e < H; e++)
                t[r][e] = (r < w && e < h) ? base + 16'(r*4 + e) : 16'h0000;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [H*BW-1:0] d, input logic rdy);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = rdy;
    endtask

    task automatic applyCfg(input int w, input int h, input int r);
        bus.cfg_load_i   = 1'b1;
        bus.cfg_width_i  = 3'(w);
        bus.cfg_height_i = 3'(h);
        bus.cfg_reuse_i  = 5'(r);
        step();
        bus.cfg_load_i   = 1'b0;
    endtask

    task automatic sendTile(input logic [15:0] base, input int beats, input logic rdy);
        for (int r = 0; r < beats; r++) begin
            applyStimulus(1'b1, mk_row(base, r), rdy);
            step();
        end
        applyStimulus(1'b0, '0, rdy);
    endtask

    task automatic test_reset();
        x_tile_fifo_flgs_t exp_f;
        exp_f = '{full: 1'b0, empty: 1'b1, level: 2'd0};
        total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        total++; if (bus.out_last_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_last: got %b want 0", bus.out_last_o); end
        total++; if (bus.flags_o !== exp_f) begin bad++; $display("[TB] FAIL reset_flags: got %b want %b", bus.flags_o, exp_f); end
        total++; if (bus.out_data_o !== tile_t'(0)) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", bus.out_data_o); end
    endtask

    task automatic test_full_tile();
        tile_t exp_t;
        exp_t = mk_tile(16'h1000, 4, 4);
        applyCfg(4, 4, 1);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, mk_row(16'h1000, r), 1'b0);
            total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL full_in_ready row%0d: got %b want 1", r, bus.in_ready_o); end
            total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL full_early_valid row%0d: got %b want 0", r, bus.out_valid_o); end
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL full_valid: got %b want 1", bus.out_valid_o); end
        total++; if (bus.out_last_o !== 1'b1) begin bad++; $display("[TB] FAIL full_last: got %b want 1", bus.out_last_o); end
        total++; if (bus.out_data_o !== exp_t) begin bad++; $display("[TB] FAIL full_data: got %h want %h", bus.out_data_o, exp_t); end
        total++; if (bus.flags_o.level !== 2'd1) begin bad++; $display("[TB] FAIL full_level: got %0d want 1", bus.flags_o.level); end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL full_drain_valid: got %b want 0", bus.out_valid_o); end
        total++; if (bus.flags_o.empty !== 1'b1) begin bad++; $display("[TB] FAIL full_drain_empty: got %b want 1", bus.flags_o.empty); end
    endtask

    task automatic test_partial();
        tile_t exp_t;
        for (int r = 0; r < W; r++)
            for (int e = 0; e < H; e++)
                exp_t[r][e] = (r < 3 && e < 2) ? 16'hFFFF : 16'h0000;
        applyCfg(3, 2, 1);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, {H*BW{1'b1}}, 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL partial_valid: got %b want 1", bus.out_valid_o); end
        total++; if (bus.out_data_o !== exp_t) begin bad++; $display("[TB] FAIL partial_data: got %h want %h", bus.out_data_o, exp_t); end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.flags_o.empty !== 1'b1) begin bad++; $display("[TB] FAIL partial_drain: got %b want 1", bus.flags_o.empty); end
    endtask

    task automatic test_cfg_clamp();
        tile_t exp_t;
        exp_t = mk_tile(16'h8000, 1, 4);
        applyCfg(0, 7, 0);
        applyStimulus(1'b1, mk_row(16'h8000, 0), 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL clamp_valid: got %b want 1", bus.out_valid_o); end
        total++; if (bus.out_last_o !== 1'b1) begin bad++; $display("[TB] FAIL clamp_last: got %b want 1", bus.out_last_o); end
        total++; if (bus.out_data_o !== exp_t) begin bad++; $display("[TB] FAIL clamp_data: got %h want %h", bus.out_data_o, exp_t); end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic test_reuse();
        tile_t exp_t;
        logic  rdy_seq [4];
        logic  last_seq [4];
        rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b1};
        last_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t    = mk_tile(16'h2000, 4, 4);
        applyCfg(4, 4, 3);
        sendTile(16'h2000, 4, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, '0, rdy_seq[c]);
            total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL reuse_valid c%0d: got %b want 1", c, bus.out_valid_o); end
            total++; if (bus.out_last_o !== last_seq[c]) begin bad++; $display("[TB] FAIL reuse_last c%0d: got %b want %b", c, bus.out_last_o, last_seq[c]); end
            total++; if (bus.out_data_o !== exp_t) begin bad++; $display("[TB] FAIL reuse_data c%0d: got %h want %h", c, bus.out_data_o, exp_t); end
            total++; if (bus.flags_o.level !== 2'd1) begin bad++; $display("[TB] FAIL reuse_level c%0d: got %0d want 1", c, bus.flags_o.level); end
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reuse_freed: got %b want 0", bus.out_valid_o); end
        total++; if (bus.flags_o.level !== 2'd0) begin bad++; $display("[TB] FAIL reuse_level_end: got %0d want 0", bus.flags_o.level); end
    endtask

    task automatic test_full_boundary();
        applyCfg(4, 4, 1);
        sendTile(16'h3000, 4, 1'b0);
        sendTile(16'h4000, 4, 1'b0);
        total++; if (bus.flags_o.full !== 1'b1) begin bad++; $display("[TB] FAIL bnd_full: got %b want 1", bus.flags_o.full); end
        total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL bnd_in_ready: got %b want 0", bus.in_ready_o); end
        // free cycle: beat C0 offered while the head tile drains
        applyStimulus(1'b1, mk_row(16'h5000, 0), 1'b1);
        total++; if (bus.flags_o.level !== 2'd2) begin bad++; $display("[TB] FAIL bnd_level_free: got %0d want 2", bus.flags_o.level); end
        total++; if (bus.out_data_o !== mk_tile(16'h3000, 4, 4)) begin bad++; $display("[TB] FAIL bnd_head_a: got %h", bus.out_data_o); end
        step();
        total++; if (bus.flags_o.level !== 2'd1) begin bad++; $display("[TB] FAIL bnd_level_after: got %0d want 1", bus.flags_o.level); end
        total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL bnd_ready_after: got %b want 1", bus.in_ready_o); end
        total++; if (bus.out_data_o !== mk_tile(16'h4000, 4, 4)) begin bad++; $display("[TB] FAIL bnd_head_b: got %h", bus.out_data_o); end
        // a config load while tiles are buffered must be ignored
        bus.cfg_load_i   = 1'b1;
        bus.cfg_width_i  = 3'd1;
        bus.cfg_height_i = 3'd1;
        bus.cfg_reuse_i  = 5'd1;
        applyStimulus(1'b1, mk_row(16'h5000, 0), 1'b0);
        step();
        bus.cfg_load_i = 1'b0;
        for (int r = 1; r < 4; r++) begin
            applyStimulus(1'b1, mk_row(16'h5000, r), 1'b0);
            step();
        end
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.flags_o.level !== 2'd2) begin bad++; $display("[TB] FAIL bnd_level_c: got %0d want 2", bus.flags_o.level); end
        total++; if (bus.out_data_o !== mk_tile(16'h4000, 4, 4)) begin bad++; $display("[TB] FAIL bnd_hold_b: got %h", bus.out_data_o); end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        total++; if (bus.out_data_o !== mk_tile(16'h5000, 4, 4)) begin bad++; $display("[TB] FAIL bnd_head_c: got %h want %h", bus.out_data_o, mk_tile(16'h5000, 4, 4)); end
        step();
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.flags_o.empty !== 1'b1) begin bad++; $display("[TB] FAIL bnd_drain: got %b want 1", bus.flags_o.empty); end
    endtask

    task automatic test_clear();
        x_tile_fifo_flgs_t exp_f;
        exp_f = '{full: 1'b0, empty: 1'b1, level: 2'd0};
        applyCfg(4, 4, 2);
        sendTile(16'h6000, 4, 1'b0);
        sendTile(16'h9000, 2, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (bus.flags_o !== exp_f) begin bad++; $display("[TB] FAIL clear_flags: got %b want %b", bus.flags_o, exp_f); end
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL clear_valid: got %b want 0", bus.out_valid_o); end
        total++; if (bus.out_data_o !== tile_t'(0)) begin bad++; $display("[TB] FAIL clear_data: got %h want 0", bus.out_data_o); end
        sendTile(16'h7000, 4, 1'b0);
        total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL clear_new_valid: got %b want 1", bus.out_valid_o); end
        total++; if (bus.out_last_o !== 1'b1) begin bad++; $display("[TB] FAIL clear_new_last: got %b want 1", bus.out_last_o); end
        total++; if (bus.out_data_o !== mk_tile(16'h7000, 4, 4)) begin bad++; $display("[TB] FAIL clear_new_data: got %h want %h", bus.out_data_o, mk_tile(16'h7000, 4, 4)); end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        total++; if (bus.flags_o.empty !== 1'b1) begin bad++; $display("[TB] FAIL clear_drain: got %b want 1", bus.flags_o.empty); end
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0);
        bus.cfg_load_i   = 1'b0;
        bus.cfg_width_i  = '0;
        bus.cfg_height_i = '0;
        bus.cfg_reuse_i  = '0;
        clear = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] starting directed scenarios");
        test_reset();
        test_full_tile();
        test_partial();
        test_cfg_clamp();
        test_reuse();
        test_full_boundary();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
